// File: rtl/riscv_dmem_responder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : riscv_dmem_responder_pkg                                        |
// | Brief    : Shared encodings and helpers for the data-memory responder.     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package riscv_dmem_responder_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE    = 2'b00,
    SIZE_HALF    = 2'b01,
    SIZE_WORD    = 2'b10,
    SIZE_ILLEGAL = 2'b11
  } dmem_size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } dmem_state_e;

  function automatic logic [29:0] word_index(input logic [31:0] addr);
    return 30'(addr >> 2);
  endfunction

endpackage
`default_nettype wire

// File: rtl/riscv_dmem_responder_be_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : riscv_dmem_responder_be_gen                                     |
// | Brief    : Byte-enable, lane-shifted write data and misalign detection.    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module riscv_dmem_responder_be_gen
  import riscv_dmem_responder_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_sh,
  output logic        misalign
);

  always_comb begin
    be       = 4'b0000;
    misalign = 1'b0;
    wdata_sh = wdata << {addr_lo, 3'b000};
    case (dmem_size_e'(size))
      SIZE_BYTE: be = 4'b0001 << addr_lo;
      SIZE_HALF: begin
        be       = 4'b0011 << addr_lo;
        misalign = addr_lo[0];
      end
      SIZE_WORD: begin
        be       = 4'b1111;
        misalign = |addr_lo;
      end
      default:   be = 4'b0000;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/riscv_dmem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : riscv_dmem_responder                                            |
// | Brief    : Valid/ready data-memory responder with configurable wait states.|
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module riscv_dmem_responder
  import riscv_dmem_responder_pkg::*;
#(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int c_aw = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_cw = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [c_cw-1:0] c_wait_load = c_cw'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
  localparam logic c_no_wait = (WAIT_CYCLES == 0);

  dmem_state_e      r_state;
  logic [c_cw-1:0]  r_cnt;
  logic             r_req_ready;
  logic             r_rsp_valid;
  logic             r_rsp_err;
  logic [31:0]      r_rsp_rdata;
  logic             r_we;
  logic             r_err;
  logic [3:0]       r_be;
  logic [31:0]      r_wdata_sh;
  logic [c_aw-1:0]  r_idx;
  logic [31:0]      r_mem [DEPTH];

  logic [3:0]       w_be;
  logic [31:0]      w_wdata_sh;
  logic             w_misalign;
  logic             w_req_err;
  logic             w_accept;
  logic             w_in_idle;
  logic             w_commit;
  logic             w_x_we;
  logic             w_x_err;
  logic [3:0]       w_x_be;
  logic [31:0]      w_x_wdata;
  logic [c_aw-1:0]  w_x_idx;
  logic [31:0]      w_load_data;

  riscv_dmem_responder_be_gen u_be_gen (
    .size     (req_size),
    .addr_lo  (req_addr[1:0]),
    .wdata    (req_wdata),
    .be       (w_be),
    .wdata_sh (w_wdata_sh),
    .misalign (w_misalign)
  );

  assign w_req_err = (dmem_size_e'(req_size) == SIZE_ILLEGAL) | w_misalign
                   | (word_index(req_addr) >= 30'(DEPTH));
  assign w_in_idle = (r_state == ST_IDLE);
  assign w_accept  = w_in_idle & req_valid & r_req_ready;

  // With no wait states the accept edge is also the RESP-entry edge, so the
  // live request fields are used instead of the captured copies.
  assign w_x_we    = w_in_idle ? req_we                   : r_we;
  assign w_x_err   = w_in_idle ? w_req_err                : r_err;
  assign w_x_be    = w_in_idle ? w_be                     : r_be;
  assign w_x_wdata = w_in_idle ? w_wdata_sh               : r_wdata_sh;
  assign w_x_idx   = w_in_idle ? req_addr[c_aw+1:2]       : r_idx;

  assign w_commit    = (w_accept & c_no_wait) | ((r_state == ST_WAIT) & (r_cnt == '0));
  assign w_load_data = (!w_x_we && !w_x_err) ? r_mem[w_x_idx] : 32'h0;

  always_ff @(posedge clk) begin
    if (w_commit && w_x_we && !w_x_err) begin
      for (int k = 0; k < 4; k++) begin
        if (w_x_be[k]) r_mem[w_x_idx][8*k +: 8] <= w_x_wdata[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= 32'h0;
      r_we        <= 1'b0;
      r_err       <= 1'b0;
      r_be        <= 4'h0;
      r_wdata_sh  <= 32'h0;
      r_idx       <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_req_ready <= 1'b1;
          if (w_accept) begin
            r_req_ready <= 1'b0;
            r_we        <= req_we;
            r_err       <= w_req_err;
            r_be        <= w_be;
            r_wdata_sh  <= w_wdata_sh;
            r_idx       <= req_addr[c_aw+1:2];
            if (c_no_wait) begin
              r_state     <= ST_RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= w_req_err;
              r_rsp_rdata <= w_load_data;
            end else begin
              r_state <= ST_WAIT;
              r_cnt   <= c_wait_load;
            end
          end
        end
        ST_WAIT: begin
          if (r_cnt == '0) begin
            r_state     <= ST_RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= r_err;
            r_rsp_rdata <= w_load_data;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_state     <= ST_IDLE;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= 32'h0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rsp_rdata = r_rsp_rdata;

endmodule
`default_nettype wire

// File: doc/riscv_dmem_responder.md
Name: riscv_dmem_responder

Overview:
Memory-side responder for the RISC-V data-memory port: serves load and store requests from the datapath over a valid/ready handshake, with configurable wait states.
- Supports byte, half and word stores via little-endian byte lanes; loads always return the full aligned word, and the datapath extracts sub-words.
- Flags misaligned, out-of-range and illegal-size accesses.
- Replaces the zero-latency data memory once the multi-cycle core lands.

Parameters:
DEPTH, 64, number of 32-bit words in the array; word index = addr[31:2]
WAIT_CYCLES, 2, cycles spent in WAIT between accept and response (0 allowed)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
req_valid  in  1  request present
req_ready  out  1  responder can accept a request
req_we  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
req_addr  in  32  byte address
req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
rsp_valid  out  1  response present
rsp_ready  in  1  requester accepts response
rsp_rdata  out  32  aligned word read (loads); 0 for stores and errors
rsp_err  out  1  access faulted; no write performed

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE, wait counter = 0.
  - req_ready = 0 while rst is low, and 1 from the first edge after deassertion.
  - rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
  - Array contents are not reset.
- States: IDLE, WAIT, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid & req_ready at a rising edge, capture we/size/addr/wdata and compute err.
  - Next state is WAIT (counter = WAIT_CYCLES-1), or RESP directly if WAIT_CYCLES == 0.
- err is set when any of the following holds:
  - size == 11;
  - half with addr[0] != 0;
  - word with addr[1:0] != 0;
  - addr[31:2] >= DEPTH.
- WAIT:
  - req_ready = 0.
  - Counter decrements each cycle; at 0, the next state is RESP.
- Entering RESP (same edge):
  - For a store with !err, write the lanes selected by the byte enables: byte = 1 << addr[1:0], half = 0011 << addr[1:0], word = 1111.
  - Lane k takes the shifted wdata byte.
  - For a load with !err, register rsp_rdata = mem[addr[31:2]].
- RESP:
  - rsp_valid = 1; rsp_rdata and rsp_err are held stable until rsp_valid & rsp_ready.
  - At that edge, go to IDLE and clear rsp_valid/rsp_rdata/rsp_err.
  - req_ready = 0 in RESP, so a new request is accepted at the earliest one cycle after the response completes.
- Latency: accept edge to rsp_valid rising = WAIT_CYCLES+1 edges (1 when WAIT_CYCLES = 0).
- Backpressure: rsp_ready low holds RESP indefinitely, with no data change.
- Errors: an err store never modifies the array; an err load returns rsp_rdata = 0.
- Reset mid-operation: a transaction in WAIT is dropped and its store is not committed. A store already committed on RESP entry stays written.
- Request fields are don't-care outside an accept edge.

Decomposition:
- Shared header riscv/dmem.vh:
  - size encodings (dmem_size_byte/half/word);
  - state encodings (dmem_st_idle/wait/resp);
  - macro for the word-index slice.
- One natural combinational sub-module, dmem_be_gen: inputs size and addr[1:0]; outputs 4-bit byte enable, the shifted 32-bit write data, and the misalign flag.
- FSM, counter and array stay in riscv_dmem_responder.

Test Plan:
- Preload mem[2]=deadbeef. Load word at addr 8, WAIT_CYCLES=2, rsp_ready=1 → rsp_valid high 3 edges after accept, rsp_rdata=deadbeef, rsp_err=0; req_ready high again one cycle after the response completes.
- Preload mem[1]=00000000. sb wdata=000000aa at addr 6, then sh wdata=0000c0de at addr 4, then load addr 4 → rdata=00aac0de.
- Preload mem[3]=c001c0de. Store word addr 0x0d (misaligned) → rsp_err=1, rdata=0; mem[3] unchanged. Repeat with size=11 and with addr=DEPTH*4 → rsp_err=1 each time.
- Load with rsp_ready held low 5 cycles → rsp_valid, rdata and err stable all 5 cycles; req_valid asserted meanwhile is not accepted (req_ready=0).
- Pull rst low during WAIT of a store of 12345678 to addr 0x10 → outputs 0 immediately; after release, a load of 0x10 returns the old value.
- WAIT_CYCLES=0 build: back-to-back loads of addrs 4 and 8 → each response 1 edge after its accept, the next accept one cycle after the prior response completes.
